// File: rtl/shift_right_iter_if.sv
// Request/result bundle for the iterative right shifter.
// Master drives the shift request; slave (the shifter) returns status and data.
// Carries no state; clock and reset stay as plain ports on the shifter.
interface shift_right_iter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start_i;
    logic               arith_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   data_o;

    modport master (
        output start_i, arith_i, shamt_i, data_i,
        input  busy_o, done_o, data_o
    );

    modport slave (
        input  start_i, arith_i, shamt_i, data_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/shift_right_iter.sv
// Iterative SRL/SRA: shifts the latched operand right one bit per clock.
// Latency: done_o rises the cycle after shamt+1 edges (accept edge included).
// Backpressure: start_i is ignored while busy; accepted in IDLE or DONE only.
module shift_right_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    shift_right_iter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               arith_q, arith_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            arith_q <= arith_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, one-bit shift per cycle in SHIFT.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        arith_d = arith_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    data_d  = bus.data_i;
                    count_d = bus.shamt_i;
                    arith_d = bus.arith_i;
                    // A zero shift needs no SHIFT cycles; report straight away.
                    state_d = (bus.shamt_i != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d  = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o = (state_q == SHIFT);
    assign bus.done_o = (state_q == DONE);
    assign bus.data_o = data_q;
endmodule

// File: tb/tb_shift_right_iter.sv
// Self-checking bench for shift_right_iter: directed cases then random operations.
// Reference result is computed with plain >> / >>> arithmetic on the operand.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_shift_right_iter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk_i;
    logic rst_i;
    int   pass_cnt;
    int   total_cnt;

    shift_right_iter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    shift_right_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [WIDTH-1:0] ref_shr(input logic [WIDTH-1:0] d,
                                                 input int s, input logic a);
        logic signed [WIDTH-1:0] sd;
        sd = $signed(d);
        if (a) return $unsigned(sd >>> s);
        return d >> s;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present a request; it is accepted on the next rising edge.
    task automatic launch(input logic [WIDTH-1:0] d, input int s, input logic a);
        bus.start_i = 1'b1;
        bus.data_i  = d;
        bus.shamt_i = SHAMT_W'(s);
        bus.arith_i = a;
    endtask

    // Run from the accept edge to the done cycle; returns at the done cycle.
    // inject=1 pulses start_i with junk operands during SHIFT.
    task automatic finish_op(input string tag, input logic [WIDTH-1:0] d,
                             input int s, input logic a, input bit inject);
        int edges;
        int busy_cycles;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        edges = 1;
        busy_cycles = 0;
        // The cycle right after the accept edge is SHIFT, or DONE for shamt=0.
        chk({tag, ".first_busy"}, WIDTH'(bus.busy_o), WIDTH'(s != 0));
        chk({tag, ".first_done"}, WIDTH'(bus.done_o), WIDTH'(s == 0));
        while (!bus.done_o && edges < 40) begin
            if (bus.busy_o) busy_cycles++;
            if (inject && edges == 2) launch($urandom, $urandom_range(1, 31), 1'b1);
            @(posedge clk_i); #1;
            bus.start_i = 1'b0;
            edges++;
        end
        chk({tag, ".latency"}, WIDTH'(edges), WIDTH'(s + 1));
        chk({tag, ".data"}, bus.data_o, ref_shr(d, s, a));
        chk({tag, ".busy_cycles"}, WIDTH'(busy_cycles), WIDTH'(s));
        chk({tag, ".busy_in_done"}, WIDTH'(bus.busy_o), '0);
    endtask

    // One edge of IDLE after a result: result held, no pulse.
    task automatic check_idle_hold(input string tag, input logic [WIDTH-1:0] res);
        @(posedge clk_i); #1;
        chk({tag, ".idle_data"}, bus.data_o, res);
        chk({tag, ".idle_done"}, WIDTH'(bus.done_o), '0);
        chk({tag, ".idle_busy"}, WIDTH'(bus.busy_o), '0);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        int               rs;
        logic             ra;
        bit               b2b;

        pass_cnt    = 0;
        total_cnt   = 0;
        rst_i       = 1'b1;
        bus.start_i = 1'b0;
        bus.arith_i = 1'b0;
        bus.shamt_i = '0;
        bus.data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.data", bus.data_o, '0);
        chk("rst.busy", WIDTH'(bus.busy_o), '0);
        chk("rst.done", WIDTH'(bus.done_o), '0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // SRL and SRA by 4
        launch(32'h8000_0010, 4, 1'b0);
        finish_op("srl4", 32'h8000_0010, 4, 1'b0, 1'b0);
        chk("srl4.value", bus.data_o, 32'h0800_0001);
        check_idle_hold("srl4", 32'h0800_0001);
        launch(32'h8000_0010, 4, 1'b1);
        finish_op("sra4", 32'h8000_0010, 4, 1'b1, 1'b0);
        chk("sra4.value", bus.data_o, 32'hF800_0001);
        check_idle_hold("sra4", 32'hF800_0001);

        // Zero shift
        launch(32'h1234_5678, 0, 1'b1);
        finish_op("sh0", 32'h1234_5678, 0, 1'b1, 1'b0);
        check_idle_hold("sh0", 32'h1234_5678);

        // Maximum shift, both fills
        launch(32'h8000_0000, 31, 1'b1);
        finish_op("sra31", 32'h8000_0000, 31, 1'b1, 1'b0);
        chk("sra31.value", bus.data_o, 32'hFFFF_FFFF);
        check_idle_hold("sra31", 32'hFFFF_FFFF);
        launch(32'h8000_0000, 31, 1'b0);
        finish_op("srl31", 32'h8000_0000, 31, 1'b0, 1'b0);
        chk("srl31.value", bus.data_o, 32'h0000_0001);
        check_idle_hold("srl31", 32'h0000_0001);

        // start_i during SHIFT is ignored; start_i in DONE is taken back-to-back
        launch(32'hC0DE_1234, 6, 1'b1);
        finish_op("ign", 32'hC0DE_1234, 6, 1'b1, 1'b1);
        launch(32'h0F0F_F0F0, 3, 1'b0);
        finish_op("b2b", 32'h0F0F_F0F0, 3, 1'b0, 1'b0);
        check_idle_hold("b2b", 32'h0F0F_F0F0 >> 3);

        // Asynchronous reset mid-shift
        launch(32'hA5A5_A5A5, 8, 1'b1);
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst.data", bus.data_o, '0);
        chk("arst.busy", WIDTH'(bus.busy_o), '0);
        chk("arst.done", WIDTH'(bus.done_o), '0);
        @(posedge clk_i); #1;
        chk("arst.held_done", WIDTH'(bus.done_o), '0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("arst.after_done", WIDTH'(bus.done_o), '0);
        launch(32'h8765_4321, 5, 1'b1);
        finish_op("post_rst", 32'h8765_4321, 5, 1'b1, 1'b0);

        // Random operations, sometimes chained back-to-back from DONE
        for (int i = 0; i < 24; i++) begin
            rd  = $urandom;
            rs  = $urandom_range(0, 31);
            ra  = 1'($urandom_range(0, 1));
            b2b = 1'($urandom_range(0, 1));
            launch(rd, rs, ra);
            finish_op($sformatf("rnd%0d", i), rd, rs, ra, 1'($urandom_range(0, 1)));
            if (!b2b) check_idle_hold($sformatf("rnd%0d", i), ref_shr(rd, rs, ra));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
